// File: rtl/driver_bus_monitor.sv
// Receive-side model of one TLC5957 lane: decodes LAT commands by SCLK-edge count,
// tracks the shift/FC registers and a GS line buffer, and flags protocol errors.
module driver_bus_monitor #(
  parameter int WORDS_PER_LINE = 9
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         driver_sclk,
  input  logic                         driver_lat,
  input  logic                         driver_sin,
  output logic                         driver_sout,
  output logic                         cmd_valid,
  output logic [2:0]                   cmd_code,
  output logic [47:0]                  fc_reg,
  output logic [48*WORDS_PER_LINE-1:0] gs_data,
  output logic                         gs_valid,
  output logic [3:0]                   err
);

  localparam int IW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0, CMD_WRTGS = 3'd1, CMD_LATGS = 3'd2, CMD_WRTFC = 3'd3,
    CMD_LINERESET = 3'd4, CMD_READFC = 3'd5, CMD_TMGRST = 3'd6, CMD_FCWRTEN = 3'd7
  } cmd_e;

  typedef enum logic {FC_LOCKED = 1'b0, FC_OPEN = 1'b1} fc_state_e;

  logic [47:0]                          shift_q, shift_d;
  logic [47:0]                          fc_q, fc_d;
  logic [WORDS_PER_LINE-1:0][47:0]      buf_q, buf_d;
  logic [48*WORDS_PER_LINE-1:0]         gs_q, gs_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [4:0]                           cnt_q, cnt_d;
  logic                                 lat_q;
  logic                                 gsv_q, gsv_d;
  logic                                 cv_q, cv_d;
  cmd_e                                 code_q, code_d, dec;
  logic [3:0]                           err_q, err_d;
  fc_state_e                            fc_state_q, fc_state_d;
  logic                                 trig;

  assign trig = lat_q & ~driver_lat;

  always_comb begin
    case (cnt_q)
      5'd1:    dec = CMD_WRTGS;
      5'd3:    dec = CMD_LATGS;
      5'd5:    dec = CMD_WRTFC;
      5'd7:    dec = CMD_LINERESET;
      5'd11:   dec = CMD_READFC;
      5'd13:   dec = CMD_TMGRST;
      5'd15:   dec = CMD_FCWRTEN;
      default: dec = CMD_NONE;
    endcase
  end

  always_comb begin
    shift_d    = driver_sclk ? {shift_q[46:0], driver_sin} : shift_q;
    cnt_d      = (driver_sclk && driver_lat && cnt_q != 5'd31) ? cnt_q + 5'd1 : cnt_q;
    fc_d       = fc_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    gs_d       = gs_q;
    gsv_d      = 1'b0;
    cv_d       = 1'b0;
    code_d     = code_q;
    err_d      = err_q;
    fc_state_d = fc_state_q;
    if (trig) begin
      // Commands act on shift_q as it stood before any shift in the trigger cycle.
      cnt_d      = 5'd0;
      cv_d       = 1'b1;
      code_d     = dec;
      fc_state_d = FC_LOCKED;
      case (dec)
        CMD_NONE: begin
          err_d[0] = 1'b1;
          if (cnt_q > 5'd15) err_d[3] = 1'b1;
        end
        CMD_WRTGS: begin
          buf_d[idx_q] = shift_q;
          if (idx_q == LAST) begin
            idx_d    = '0;
            err_d[2] = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        CMD_LATGS, CMD_LINERESET: begin
          buf_d[idx_q] = shift_q;
          if (idx_q != LAST) err_d[2] = 1'b1;
          for (int i = 0; i < WORDS_PER_LINE; i++)
            gs_d[(WORDS_PER_LINE-1-i)*48 +: 48] = buf_d[i];
          gsv_d = 1'b1;
          idx_d = '0;
        end
        CMD_WRTFC: begin
          if (fc_state_q == FC_OPEN) fc_d = shift_q;
          else err_d[1] = 1'b1;
        end
        CMD_READFC:  shift_d = fc_q;
        CMD_TMGRST:  idx_d = '0;
        CMD_FCWRTEN: fc_state_d = FC_OPEN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) fc_state_q <= FC_LOCKED;
    else       fc_state_q <= fc_state_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_q <= '0;
      fc_q    <= '0;
      buf_q   <= '0;
      gs_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= 1'b0;
      gsv_q   <= 1'b0;
      cv_q    <= 1'b0;
      code_q  <= CMD_NONE;
      err_q   <= '0;
    end else begin
      shift_q <= shift_d;
      fc_q    <= fc_d;
      buf_q   <= buf_d;
      gs_q    <= gs_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lat_q   <= driver_lat;
      gsv_q   <= gsv_d;
      cv_q    <= cv_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign driver_sout = shift_q[47];
  assign cmd_valid   = cv_q;
  assign cmd_code    = code_q;
  assign fc_reg      = fc_q;
  assign gs_data     = gs_q;
  assign gs_valid    = gsv_q;
  assign err         = err_q;

endmodule
